// File: rtl/alu_pkg.sv
// Shared constants, opcode and FSM encodings for the ALU front-end controller.
// Operand width, selector width and MUL/DIV iteration count live here.
package alu_pkg;

  localparam int DW    = 8;
  localparam int OPW   = 4;
  localparam int ITERS = DW;
  localparam int CW    = $clog2(ITERS);

  typedef enum logic [OPW-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOT    = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_MUL    = 4'd8,
    OP_DIV    = 4'd9,
    OP_RSV_LO = 4'd10,
    OP_RSV_HI = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ITER = 3'd1,
    ST_EXEC = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic is_iter_op(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Slots 10..15 of the result mux carry nothing meaningful.
  function automatic logic is_illegal_op(input logic [OPW-1:0] op);
    return op >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one step per cycle.
// start loads the operands; done is high during the last step.
module alu_muldiv_iter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic            div0,
  output logic [2*DW-1:0] result
);

  logic            busy;
  logic            div_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   work;
  logic [DW-1:0]   rem;
  logic [CW-1:0]   count;

  logic [DW:0]     rem_sh;
  logic [DW+1:0]   trial;

  // Restoring step: shift next dividend bit into the remainder, try subtracting the divisor.
  always_comb begin
    rem_sh = {rem, work[DW-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      mcand <= '0;
      work  <= '0;
      rem   <= '0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      a_q   <= a;
      b_q   <= b;
      acc   <= '0;
      mcand <= {{DW{1'b0}}, a};
      work  <= is_div ? a : b;
      rem   <= '0;
      count <= '0;
    end else if (busy) begin
      if (!div_q) begin
        if (work[0]) begin
          acc <= acc + mcand;
        end
        mcand <= mcand << 1;
        work  <= work >> 1;
      end else if (!trial[DW+1]) begin
        rem  <= trial[DW-1:0];
        work <= {work[DW-2:0], 1'b1};
      end else begin
        rem  <= rem_sh[DW-1:0];
        work <= {work[DW-2:0], 1'b0};
      end
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  always_comb begin
    done = busy && (count == CW'(ITERS - 1));
    div0 = div_q && (b_q == '0);
    if (!div_q) begin
      result = acc;
    end else if (div0) begin
      result = {a_q, {DW{1'b1}}};
    end else begin
      result = {rem, work};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end controller of the ALU: accepts one op per handshake, drives the result-mux
// selector, runs MUL/DIV iteratively and registers the mux output for the consumer.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic [OPW-1:0]  in_op,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic [OPW-1:0]  selectors,
  output logic [2*DW-1:0] md_result,
  input  logic [2*DW-1:0] mux_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_result,
  output logic            out_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; in_ready is
  // high only in IDLE, out_valid holds with stable data until out_ready takes it.
  state_e state;
  state_e state_next;

  logic accept;
  logic consume;
  logic md_start;
  logic md_done;
  logic md_div0;

  alu_muldiv_iter u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (in_op == OP_DIV),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .div0   (md_div0),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_iter_op(in_op) ? ST_ITER : ST_EXEC;
      ST_ITER: if (md_done) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_CAPT;
      ST_CAPT: state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    accept   = in_valid && in_ready;
    md_start = accept && is_iter_op(in_op);
    consume  = (state == ST_DONE) && out_ready;
  end

  // Operand/selector latches hold the last accepted op until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      selectors  <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        op_a      <= in_a;
        op_b      <= in_b;
        selectors <= in_op;
      end
      if (state == ST_CAPT) begin
        out_result <= is_illegal_op(selectors) ? '0 : mux_out;
        out_err    <= is_illegal_op(selectors) || ((selectors == OP_DIV) && md_div0);
        out_valid  <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a reference result mux, an arithmetic model
// with an expected queue, a per-cycle compare process and literal spot checks.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_op;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [3:0]  selectors;
  logic [15:0] md_result;
  logic [15:0] mux_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  cur_a   = 8'h00;
  logic [7:0]  cur_b   = 8'h00;
  logic [3:0]  cur_op  = 4'h0;
  logic        seen    = 1'b0;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .selectors  (selectors),
    .md_result  (md_result),
    .mux_out    (mux_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Combinational op units plus the 16:1 result mux outside the controller.
  always_comb begin
    case (selectors)
      4'd0:    mux_out = 16'(op_a) + 16'(op_b);
      4'd1:    mux_out = 16'(op_a) - 16'(op_b);
      4'd2:    mux_out = {8'h00, op_a & op_b};
      4'd3:    mux_out = {8'h00, op_a | op_b};
      4'd4:    mux_out = {8'h00, op_a ^ op_b};
      4'd5:    mux_out = {8'h00, ~op_a};
      4'd6:    mux_out = 16'(op_a) << op_b[2:0];
      4'd7:    mux_out = 16'(op_a) >> op_b[2:0];
      4'd8:    mux_out = md_result;
      4'd9:    mux_out = md_result;
      default: mux_out = 16'hDEAD;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {err, result} straight from the opcode definitions.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      4'd0: return {1'b0, 16'(ia + ib)};
      4'd1: return {1'b0, 16'(ia - ib)};
      4'd2: return {1'b0, 8'h00, a & b};
      4'd3: return {1'b0, 8'h00, a | b};
      4'd4: return {1'b0, 8'h00, a ^ b};
      4'd5: return {1'b0, 8'h00, ~a};
      4'd6: return {1'b0, 16'(ia << b[2:0])};
      4'd7: return {1'b0, 16'(ia >> b[2:0])};
      4'd8: return {1'b0, 16'(ia * ib)};
      4'd9: begin
        if (ib == 0) return {1'b1, a, 8'hFF};
        return {1'b0, 8'(ia % ib), 8'(ia / ib)};
      end
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // Compare process: latched operands every cycle, result once per out_valid rise.
  always @(negedge clk) begin
    if (rst_n) begin
      check("op_a", 32'(op_a), 32'(cur_a));
      check("op_b", 32'(op_b), 32'(cur_b));
      check("selectors", 32'(selectors), 32'(cur_op));
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("out_result", 32'(out_result), 32'(e[15:0]));
          check("out_err", 32'(out_err), 32'(e[16]));
        end
      end
      if (!out_valid) seen = 1'b0;
    end
  end

  // hold < 0: out_ready high from before accept; hold > 0: backpressure cycles.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input int hold, input bit chk_lit, input logic [16:0] lit);
    int          edges;
    bit          got;
    logic [16:0] snap;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'(1));
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    if (hold < 0) out_ready = 1'b1;
    @(posedge clk);
    cur_a = a; cur_b = b; cur_op = op;
    exp_q.push_back(model(a, b, op));
    #1;
    in_valid = 1'b0;
    in_a = 8'($urandom_range(0, 255));
    in_b = 8'($urandom_range(0, 255));
    in_op = 4'($urandom_range(0, 15));
    edges = 1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      check("in_ready_busy", 32'(in_ready), 32'(0));
      @(posedge clk);
      edges++;
    end
    if (!got) begin
      check("timeout_out_valid", 32'(out_valid), 32'(1));
      out_ready = 1'b0;
      return;
    end
    check("latency", 32'(edges), (op == 4'd8 || op == 4'd9) ? 32'(11) : 32'(3));
    if (chk_lit) check("literal", 32'({out_err, out_result}), 32'(lit));
    snap = {out_err, out_result};
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_a = ~a; in_b = ~b; in_op = 4'd0;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_hold", 32'({out_err, out_result}), 32'(snap));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("consumed", 32'(out_valid), 32'(0));
    check("idle_ready", 32'(in_ready), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op_a"}, 32'(op_a), 32'(0));
    check({tag, "_op_b"}, 32'(op_b), 32'(0));
    check({tag, "_selectors"}, 32'(selectors), 32'(0));
    check({tag, "_md_result"}, 32'(md_result), 32'(0));
    check({tag, "_out_result"}, 32'(out_result), 32'(0));
    check({tag, "_out_err"}, 32'(out_err), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'h01, 4'd0, 0, 1'b1, 17'h00100);
    run_op(8'hFF, 8'hFF, 4'd8, 0, 1'b1, 17'h0FE01);
    run_op(8'd200, 8'd7, 4'd9, 0, 1'b1, 17'h0041C);
    run_op(8'h55, 8'h00, 4'd9, 0, 1'b1, 17'h155FF);
    run_op(8'h5A, 8'h33, 4'd12, 0, 1'b1, 17'h10000);
    check("sel_reserved", 32'(selectors), 32'(12));

    run_op(8'h03, 8'h05, 4'd1, 0, 1'b1, 17'h0FFFE);
    run_op(8'hF0, 8'h3C, 4'd2, 0, 1'b0, 17'h0);
    run_op(8'hF0, 8'h0F, 4'd3, -1, 1'b0, 17'h0);
    run_op(8'hAA, 8'hFF, 4'd4, 0, 1'b0, 17'h0);
    run_op(8'h0F, 8'h00, 4'd5, 0, 1'b1, 17'h000F0);
    run_op(8'h81, 8'hFB, 4'd6, 0, 1'b1, 17'h00408);
    run_op(8'h81, 8'h0F, 4'd7, -1, 1'b1, 17'h00001);
    run_op(8'd13, 8'd11, 4'd8, 0, 1'b1, 17'h0008F);
    run_op(8'hFF, 8'h10, 4'd9, 0, 1'b1, 17'h00F0F);
    run_op(8'h07, 8'hFF, 4'd9, -1, 1'b1, 17'h00700);
    run_op(8'h00, 8'h00, 4'd8, 0, 1'b0, 17'h0);
    run_op(8'h11, 8'h22, 4'd15, 0, 1'b1, 17'h10000);
    run_op(8'h12, 8'h34, 4'd0, 5, 1'b1, 17'h00046);

    // Reset during a MUL: nothing may be emitted, next op runs clean.
    @(negedge clk);
    in_a = 8'hFF; in_b = 8'hFF; in_op = 4'd8; in_valid = 1'b1;
    @(posedge clk);
    cur_a = 8'hFF; cur_b = 8'hFF; cur_op = 4'd8;
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    cur_a = 8'h00; cur_b = 8'h00; cur_op = 4'h0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h04, 4'd0, 0, 1'b1, 17'h00007);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
